stump_mem_responder: RTL and testbench
======================================

// Module: stump_mem_responder
// PURPOSE
//  Memory-side responder for the Stump CPU bus: answers address/data_out/mem_wen/mem_ren
//  and returns read data to the CPU's data_in. Holds word RAM below IO_BASE, plus an IO page
//  with an 8-deep TX FIFO, a 1-entry RX holding register and a compare timer.
//  Sits beside Stump in the system top; the CPU has no wait state, so reads are same-cycle.
// PARAMETERS
//  RAM_AW      12        RAM word-address width (2**RAM_AW x 16b words; aliases below IO_BASE)
//  IO_BASE     16'hFF00  first IO address; address >= IO_BASE is the IO page
//  FIFO_DEPTH  8         TX FIFO entries (power of 2)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  address    in   16  CPU word address
//  wdata      in   16  CPU store data (Stump data_out)
//  mem_wen    in   1   CPU write strobe
//  mem_ren    in   1   CPU read strobe
//  rdata      out  16  read data to CPU data_in (combinational)
//  tx_data    out  16  head of TX FIFO
//  tx_valid   out  1   TX FIFO non-empty
//  tx_ready   in   1   sink accepts tx_data this cycle
//  rx_data    in   16  incoming word
//  rx_valid   in   1   rx_data valid
//  rx_ready   out  1   RX holding register empty
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty (tx_valid=0), overflow=0, rx_full=0 (rx_ready=1),
//   timer count=0, enable=0, flag=0, compare=16'hFFFF. RAM contents not reset.
//  Bus: rdata = 0 unless mem_ren=1 and mem_wen=0. mem_wen&mem_ren together = write only.
//   RAM read async: rdata = ram[address[RAM_AW-1:0]]; write on clk edge when mem_wen.
//  IO map (offset from IO_BASE); unmapped offsets read 0, writes ignored:
//   +0 TXDATA  W: push wdata; R: {12'b0, tx_count[3:0]}
//   +1 STATUS  R: [0]tx_full [1]tx_empty [2]rx_full [3]timer_flag [4]overflow [15:5]0
//              W: wdata[4]=1 clears overflow
//   +2 RXDATA  R: holding reg, pops (rx_full<=0 at edge); read when empty returns last value
//   +3 TIMER   R: count; W: compare<=wdata, count<=0
//   +4 TCTRL   R: {15'b0,enable}; W: enable<=wdata[0]; wdata[1]=1 clears flag
//  TX FIFO: push when write to +0; pop when tx_valid&tx_ready. tx_data from head, stable
//   until popped. Full & push & no pop: data dropped, overflow<=1 (sticky).
//   Full & push & pop same cycle: both happen, count unchanged. Empty: pop impossible.
//   Pointers wrap modulo FIFO_DEPTH; count is log2(DEPTH)+1 bits.
//  RX: capture rx_data when rx_valid&rx_ready; rx_full<=1. CPU pop and capture never
//   coincide (rx_ready=0 while full); capture resumes the cycle after pop.
//  Timer: when enable, count increments each cycle; when count==compare: count<=0, flag<=1.
//   Flag set and software clear in same cycle: set wins. compare=0 => flag every cycle.
//   Write to +3 while enabled restarts from 0 next cycle.
//  Side effects (pop, push, clears) occur only on the clk edge ending the access cycle.
// STRUCTURE
//  Shared `include "Stump/Stump_mem_map.v": IO_BASE, register offsets, STATUS bit indices.
//  Sub-module stump_tx_fifo (push/pop/full/empty/count/head); remainder in this module:
//  address decode, RAM array, RX register, timer, read mux.
// TESTING
//  Reset then write RAM 0x0010<=16'h1234, read 0x0010 -> rdata=16'h1234; 0x1010 aliases (RAM_AW=12).
//  tx_ready=0, push 9 words 1..9 -> STATUS=16'h0011 (full, overflow), TXDATA reads 8; release
//   tx_ready -> tx_data 1..8 in order, tx_valid drops after 8 pops.
//  FIFO full, push 16'hAA with tx_ready=1 same cycle -> count stays 8, 16'hAA last out.
//  rx_valid pulse with 16'hBEEF -> rx_ready=0, STATUS[2]=1; read +2 -> BEEF, rx_ready=1 next cycle.
//  compare=3, TCTRL=1 -> flag set 4 cycles after enable, count back to 0; clear at same edge
//   as next match -> flag remains 1.
//  rst low mid-burst (FIFO holding 3) -> tx_valid=0, rx_ready=1, compare=16'hFFFF immediately.

Source files
------------

// File: rtl/stump_mem_responder_pkg.sv
// Shared definitions for the Stump memory responder: IO page register offsets,
// STATUS/TCTRL bit positions, reset values and the IO offset decoder.
package stump_mem_responder_pkg;

   localparam logic [15:0] OFF_TXDATA = 16'd0;
   localparam logic [15:0] OFF_STATUS = 16'd1;
   localparam logic [15:0] OFF_RXDATA = 16'd2;
   localparam logic [15:0] OFF_TIMER  = 16'd3;
   localparam logic [15:0] OFF_TCTRL  = 16'd4;

   localparam int ST_TX_FULL    = 0;
   localparam int ST_TX_EMPTY   = 1;
   localparam int ST_RX_FULL    = 2;
   localparam int ST_TIMER_FLAG = 3;
   localparam int ST_OVERFLOW   = 4;

   localparam int TCTRL_ENABLE   = 0;
   localparam int TCTRL_CLR_FLAG = 1;

   localparam logic [15:0] TIMER_CMP_RST = 16'hFFFF;

   typedef enum logic [2:0] {
      IO_TXDATA,
      IO_STATUS,
      IO_RXDATA,
      IO_TIMER,
      IO_TCTRL,
      IO_NONE
   } io_reg_e;

   function automatic io_reg_e io_decode(input logic [15:0] off);
      io_reg_e sel;
      case (off)
         OFF_TXDATA: sel = IO_TXDATA;
         OFF_STATUS: sel = IO_STATUS;
         OFF_RXDATA: sel = IO_RXDATA;
         OFF_TIMER:  sel = IO_TIMER;
         OFF_TCTRL:  sel = IO_TCTRL;
         default:    sel = IO_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/stump_tx_fifo.sv
// Transmit FIFO: fall-through head, simultaneous push/pop allowed when full,
// and a one-cycle drop pulse when a push is refused.
module stump_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          drop_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
   assign do_push = push_i & (~full_o | do_pop);
   assign drop_o  = push_i & full_o & ~do_pop;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/stump_mem_responder.sv
// Memory-side responder for the Stump CPU bus: aliased word RAM below IO_BASE and an
// IO page with TX FIFO, RX holding register and compare timer. Reads are same-cycle.
module stump_mem_responder
   import stump_mem_responder_pkg::*;
#(
   parameter int          RAM_AW     = 12,
   parameter logic [15:0] IO_BASE    = 16'hFF00,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   input  logic        mem_wen,
   input  logic        mem_ren,
   output logic [15:0] rdata,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [15:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          is_io;
   logic [15:0]   io_off;
   io_reg_e       io_sel;
   logic          rd_acc, wr_acc;
   logic [15:0]   io_rdata;
   logic [15:0]   status;

   logic [15:0]   ram_q [2**RAM_AW];

   logic          tx_push, tx_pop, tx_full, tx_empty, tx_drop;
   logic [CW-1:0] tx_count;
   logic          overflow_q, overflow_d;

   logic          rx_full_q, rx_full_d;
   logic [15:0]   rx_data_q, rx_data_d;
   logic          rx_capture, rx_pop;

   logic [15:0]   count_q, count_d;
   logic [15:0]   compare_q, compare_d;
   logic          enable_q, enable_d;
   logic          flag_q, flag_d;
   logic          timer_wr, tctrl_wr, timer_match;

   // A write strobe always wins: mem_wen & mem_ren is a pure write with no read side effects.
   assign rd_acc = mem_ren & ~mem_wen;
   assign wr_acc = mem_wen;
   assign is_io  = (address >= IO_BASE);
   assign io_off = address - IO_BASE;
   assign io_sel = is_io ? io_decode(io_off) : IO_NONE;

   always_ff @(posedge clk) begin
      if (wr_acc && !is_io) ram_q[address[RAM_AW-1:0]] <= wdata;
   end

   assign tx_push  = wr_acc && (io_sel == IO_TXDATA);
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_valid = ~tx_empty;

   stump_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
   ) u_tx_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .data_i  (wdata),
      .head_o  (tx_data),
      .count_o (tx_count),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .drop_o  (tx_drop)
   );

   assign rx_ready   = ~rx_full_q;
   assign rx_capture = rx_valid & rx_ready;
   assign rx_pop     = rd_acc && (io_sel == IO_RXDATA);

   assign timer_wr    = wr_acc && (io_sel == IO_TIMER);
   assign tctrl_wr    = wr_acc && (io_sel == IO_TCTRL);
   assign timer_match = enable_q && (count_q == compare_q);

   always_comb begin
      overflow_d = overflow_q;
      rx_full_d  = rx_full_q;
      rx_data_d  = rx_data_q;
      count_d    = count_q;
      compare_d  = compare_q;
      enable_d   = enable_q;
      flag_d     = flag_q;

      if (tx_drop) overflow_d = 1'b1;
      if (wr_acc && (io_sel == IO_STATUS) && wdata[ST_OVERFLOW]) overflow_d = 1'b0;

      if (rx_pop) rx_full_d = 1'b0;
      if (rx_capture) begin
         rx_full_d = 1'b1;
         rx_data_d = rx_data;
      end

      if (timer_match)   count_d = '0;
      else if (enable_q) count_d = count_q + 16'd1;
      if (timer_wr) begin
         compare_d = wdata;
         count_d   = '0;
      end
      if (tctrl_wr) begin
         enable_d = wdata[TCTRL_ENABLE];
         if (wdata[TCTRL_CLR_FLAG]) flag_d = 1'b0;
      end
      // Hardware set is applied last so it beats a coincident software clear.
      if (timer_match) flag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
         rx_full_q  <= 1'b0;
         rx_data_q  <= '0;
         count_q    <= '0;
         compare_q  <= TIMER_CMP_RST;
         enable_q   <= 1'b0;
         flag_q     <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
         rx_full_q  <= rx_full_d;
         rx_data_q  <= rx_data_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         enable_q   <= enable_d;
         flag_q     <= flag_d;
      end
   end

   always_comb begin
      status                = '0;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_EMPTY]   = tx_empty;
      status[ST_RX_FULL]    = rx_full_q;
      status[ST_TIMER_FLAG] = flag_q;
      status[ST_OVERFLOW]   = overflow_q;
   end

   always_comb begin
      io_rdata = '0;
      case (io_sel)
         IO_TXDATA: io_rdata = {{(16-CW){1'b0}}, tx_count};
         IO_STATUS: io_rdata = status;
         IO_RXDATA: io_rdata = rx_data_q;
         IO_TIMER:  io_rdata = count_q;
         IO_TCTRL:  io_rdata = {15'b0, enable_q};
         default:   io_rdata = '0;
      endcase
   end

   always_comb begin
      rdata = '0;
      if (rd_acc) rdata = is_io ? io_rdata : ram_q[address[RAM_AW-1:0]];
   end

endmodule

// File: tb/tb_stump_mem_responder.sv
// Directed bench for stump_mem_responder; a negedge monitor checks TX output
// against a queue of words the bench expects the FIFO to hold.
module tb_stump_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address, wdata, rdata, tx_data, rx_data;
   logic        mem_wen, mem_ren, tx_valid, tx_ready, rx_valid, rx_ready;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];
   bit          mon_en = 1'b0;

   always #5 clk = ~clk;

   stump_mem_responder dut (
      .clk      (clk),
      .rst      (rst),
      .address  (address),
      .wdata    (wdata),
      .mem_wen  (mem_wen),
      .mem_ren  (mem_ren),
      .rdata    (rdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bit accept;
      address = a;
      wdata   = d;
      mem_wen = 1'b1;
      mem_ren = 1'b0;
      accept  = (a == 16'hFF00) && ((exp_q.size() < 8) || (tx_ready && exp_q.size() > 0));
      step();
      if (accept) exp_q.push_back(d);
      mem_wen = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] expv, input string tag);
      address = a;
      mem_ren = 1'b1;
      mem_wen = 1'b0;
      #1;
      chk(tag, rdata, expv);
      step();
      mem_ren = 1'b0;
   endtask

   task automatic drain(input string tag);
      tx_ready = 1'b1;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
      chk(tag, 16'(exp_q.size()), 16'd0);
      tx_ready = 1'b0;
      chk({tag, "_txv"}, {15'b0, tx_valid}, 16'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("tx_valid", {15'b0, tx_valid}, {15'b0, (exp_q.size() != 0)});
         if (tx_valid && tx_ready && exp_q.size() > 0) begin
            chk("tx_data", tx_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; address = '0; wdata = '0; mem_wen = 1'b0; mem_ren = 1'b0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      step(); step();

      chk("rst_txv", {15'b0, tx_valid}, 16'd0);
      chk("rst_rxr", {15'b0, rx_ready}, 16'd1);
      rd(16'hFF01, 16'h0002, "rst_status");
      rd(16'hFF03, 16'h0000, "rst_timer");
      rst = 1'b1;
      mon_en = 1'b1;

      // RAM and aliasing
      wr(16'h0010, 16'h1234);
      rd(16'h0010, 16'h1234, "ram_rd");
      rd(16'h1010, 16'h1234, "ram_alias");
      wr(16'h2020, 16'h5678);
      rd(16'h0020, 16'h5678, "ram_alias_wr");
      address = 16'h0010; wdata = 16'h9999; mem_wen = 1'b1; mem_ren = 1'b1;
      #1;
      chk("wen_ren_rdata", rdata, 16'h0000);
      step();
      mem_wen = 1'b0; mem_ren = 1'b0;
      rd(16'h0010, 16'h9999, "wen_ren_wrote");
      address = 16'h0010;
      #1;
      chk("no_ren", rdata, 16'h0000);

      // TX FIFO overflow
      for (int i = 1; i <= 9; i++) wr(16'hFF00, 16'(i));
      rd(16'hFF01, 16'h0011, "ovf_status");
      rd(16'hFF00, 16'h0008, "ovf_count");
      wr(16'hFF01, 16'h0010);
      rd(16'hFF01, 16'h0001, "ovf_clear");
      drain("drain1");
      rd(16'hFF01, 16'h0002, "empty_status");

      // full FIFO with simultaneous push and pop
      for (int i = 1; i <= 8; i++) wr(16'hFF00, 16'h0100 + 16'(i));
      tx_ready = 1'b1;
      wr(16'hFF00, 16'h00AA);
      tx_ready = 1'b0;
      rd(16'hFF00, 16'h0008, "pushpop_count");
      rd(16'hFF01, 16'h0001, "pushpop_status");
      drain("drain2");

      // RX holding register
      rx_data = 16'hBEEF; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      chk("rx_full_rdy", {15'b0, rx_ready}, 16'd0);
      rd(16'hFF01, 16'h0006, "rx_status");
      rx_data = 16'hCAFE; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      rd(16'hFF02, 16'hBEEF, "rx_pop");
      chk("rx_after_pop", {15'b0, rx_ready}, 16'd1);
      rd(16'hFF02, 16'hBEEF, "rx_last");
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      rd(16'hFF02, 16'hCAFE, "rx_second");

      // compare timer
      wr(16'hFF03, 16'h0003);
      wr(16'hFF04, 16'h0001);
      rd(16'hFF03, 16'h0000, "tmr_c0");
      rd(16'hFF03, 16'h0001, "tmr_c1");
      rd(16'hFF01, 16'h0002, "tmr_noflag");
      rd(16'hFF03, 16'h0003, "tmr_c3");
      rd(16'hFF01, 16'h000A, "tmr_flag");
      rd(16'hFF03, 16'h0001, "tmr_wrap");
      step();
      wr(16'hFF04, 16'h0003);
      rd(16'hFF01, 16'h000A, "tmr_setwins");
      wr(16'hFF04, 16'h0003);
      rd(16'hFF01, 16'h0002, "tmr_clr");
      rd(16'hFF04, 16'h0001, "tctrl");
      wr(16'hFF04, 16'h0002);
      rd(16'hFF01, 16'h0002, "tmr_off");

      // unmapped IO
      wr(16'hFF07, 16'h5555);
      rd(16'hFF07, 16'h0000, "unmapped7");
      rd(16'hFF05, 16'h0000, "unmapped5");

      // reset in the middle of activity
      wr(16'hFF03, 16'h0005);
      for (int i = 1; i <= 3; i++) wr(16'hFF00, 16'h0200 + 16'(i));
      rx_data = 16'h1111; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      chk("pre_rst_rxr", {15'b0, rx_ready}, 16'd0);
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_txv", {15'b0, tx_valid}, 16'd0);
      chk("mid_rst_rxr", {15'b0, rx_ready}, 16'd1);
      step();
      rst = 1'b1;
      wr(16'hFF04, 16'h0001);
      repeat (10) step();
      rd(16'hFF03, 16'd10, "rst_compare");
      rd(16'hFF01, 16'h0002, "rst_noflag");

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
